// File: rtl/icache.sv
// Direct-mapped instruction cache, 16-byte lines, refill from memctrl with bypass of the returned word.
// Optional hit/miss counters when ICACHE_STAT_EN is defined.
module icache #(
    parameter int unsigned IDX_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         if_valid,
    input  logic [31:0]  if_pc,
    input  logic         if_rb,
    output logic         if_done,
    output logic [31:0]  if_inst,
    output logic         mc_fc_valid,
    output logic [31:0]  mc_fc_addr,
    input  logic         mc_fc_done,
    input  logic [127:0] mc_fc_line
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);

    localparam int unsigned TAG_W = 32 - IDX_W - 4;
    localparam int unsigned LINES = 2 ** IDX_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t             state;
    logic [127:0]       data_q [LINES];
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [LINES-1:0]   valid_q;
    logic [31:2]        req_pc;
    logic               squash;

    logic [IDX_W-1:0]   lk_idx_c;
    logic [TAG_W-1:0]   lk_tag_c;
    logic [IDX_W-1:0]   rf_idx_c;
    logic               hit_c;
    logic               lookup_c;
    logic               fill_c;
    logic               unused_pc_c;

    function automatic logic [31:0] word_sel(input logic [127:0] line, input logic [1:0] w);
        case (w)
            2'd0:    return line[31:0];
            2'd1:    return line[63:32];
            2'd2:    return line[95:64];
            default: return line[127:96];
        endcase
    endfunction

    assign unused_pc_c = ^if_pc[1:0];
    assign lk_idx_c    = if_pc[IDX_W+3:4];
    assign lk_tag_c    = if_pc[31:IDX_W+4];
    assign rf_idx_c    = req_pc[IDX_W+3:4];
    assign hit_c       = valid_q[lk_idx_c] && (tag_q[lk_idx_c] == lk_tag_c);
    // No new lookup while if_done is high: the requester has not yet seen the pulse.
    assign lookup_c    = (state == S_IDLE) && rdy && if_valid && !if_rb && !if_done;
    assign fill_c      = (state == S_WAIT) && mc_fc_done;

    // Line storage is not reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_c) begin
            data_q[rf_idx_c] <= mc_fc_line;
            tag_q[rf_idx_c]  <= req_pc[31:IDX_W+4];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            valid_q     <= '0;
            req_pc      <= '0;
            squash      <= 1'b0;
            if_done     <= 1'b0;
            if_inst     <= '0;
            mc_fc_valid <= 1'b0;
            mc_fc_addr  <= '0;
`ifdef ICACHE_STAT_EN
            hit_cnt     <= '0;
            miss_cnt    <= '0;
`endif
        end else begin
            if_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    squash <= 1'b0;
                    if (lookup_c) begin
                        if (hit_c) begin
                            if_done <= 1'b1;
                            if_inst <= word_sel(data_q[lk_idx_c], if_pc[3:2]);
`ifdef ICACHE_STAT_EN
                            hit_cnt <= hit_cnt + 32'd1;
`endif
                        end else begin
                            req_pc      <= if_pc[31:2];
                            mc_fc_valid <= 1'b1;
                            mc_fc_addr  <= {if_pc[31:4], 4'b0};
                            state       <= S_WAIT;
`ifdef ICACHE_STAT_EN
                            miss_cnt    <= miss_cnt + 32'd1;
`endif
                        end
                    end
                end
                S_WAIT: begin
                    if (mc_fc_done) begin
                        valid_q[rf_idx_c] <= 1'b1;
                        mc_fc_valid       <= 1'b0;
                        if_inst           <= word_sel(mc_fc_line, req_pc[3:2]);
                        if (if_rb || squash) begin
                            state <= S_IDLE;
                        end else if (rdy) begin
                            if_done <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            state <= S_HOLD;
                        end
                    end else if (if_rb) begin
                        squash <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // Line already filled; only the response waits for rdy.
                    if (if_rb || squash) begin
                        state <= S_IDLE;
                    end else if (rdy) begin
                        if_done <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: vector table of fetches plus hand sequences for
// rollback, rdy stalls at refill completion and asynchronous reset mid-refill.
module tb_icache;

    logic         clk = 1'b0;
    logic         rst;
    logic         rdy;
    logic         if_valid;
    logic [31:0]  if_pc;
    logic         if_rb;
    logic         if_done;
    logic [31:0]  if_inst;
    logic         mc_fc_valid;
    logic [31:0]  mc_fc_addr;
    logic         mc_fc_done;
    logic [127:0] mc_fc_line;
`ifdef ICACHE_STAT_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    icache #(.IDX_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_valid(if_valid), .if_pc(if_pc), .if_rb(if_rb),
        .if_done(if_done), .if_inst(if_inst),
        .mc_fc_valid(mc_fc_valid), .mc_fc_addr(mc_fc_addr),
        .mc_fc_done(mc_fc_done), .mc_fc_line(mc_fc_line)
`ifdef ICACHE_STAT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int req_cnt = 0;
    int done_cnt = 0;
    int exp_hit = 0;
    int exp_miss = 0;
    logic fc_prev = 1'b0;

    localparam logic [127:0] LINE_A = 128'h33221100_77665544_BBAA9988_FFEEDDCC;
    localparam logic [127:0] LINE_B = 128'h0000000D_0000000C_0000000B_0000000A;
    localparam logic [127:0] LINE_C = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
    localparam logic [127:0] LINE_D = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
    localparam logic [127:0] LINE_E = 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0;
    localparam logic [127:0] LINE_F = 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0;

    // Pre-edge values: counts request rising edges and if_done pulses.
    always @(posedge clk) begin
        if (mc_fc_valid && !fc_prev) req_cnt++;
        fc_prev = mc_fc_valid;
        if (if_done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_stats();
`ifdef ICACHE_STAT_EN
        check("hit_cnt", hit_cnt, 32'(exp_hit));
        check("miss_cnt", miss_cnt, 32'(exp_miss));
`endif
    endtask

    task automatic fetch_hit(input logic [31:0] pc, input logic [31:0] exp);
        if_valid = 1'b1;
        if_pc    = pc;
        @(negedge clk);
        check("hit_done", 32'(if_done), 32'd1);
        check("hit_inst", if_inst, exp);
        check("hit_noreq", 32'(mc_fc_valid), 32'd0);
        exp_hit++;
        if_valid = 1'b0;
        @(negedge clk);
        check("hit_single", 32'(if_done), 32'd0);
    endtask

    task automatic start_miss(input logic [31:0] pc);
        if_valid = 1'b1;
        if_pc    = pc;
        @(negedge clk);
        check("req_valid", 32'(mc_fc_valid), 32'd1);
        check("req_addr", mc_fc_addr, {pc[31:4], 4'b0});
        exp_miss++;
    endtask

    task automatic fetch_miss(input logic [31:0] pc, input logic [127:0] line,
                              input int lat, input logic [31:0] exp);
        int r0;
        r0 = req_cnt;
        start_miss(pc);
        repeat (lat - 1) begin
            @(negedge clk);
            check("wait_nodone", 32'(if_done), 32'd0);
            check("wait_valid", 32'(mc_fc_valid), 32'd1);
        end
        mc_fc_done = 1'b1;
        mc_fc_line = line;
        @(negedge clk);
        mc_fc_done = 1'b0;
        if_valid   = 1'b0;
        check("fill_done", 32'(if_done), 32'd1);
        check("fill_inst", if_inst, exp);
        check("fill_drop", 32'(mc_fc_valid), 32'd0);
        @(negedge clk);
        check("fill_single", 32'(if_done), 32'd0);
        check("one_req", 32'(req_cnt - r0), 32'd1);
    endtask

    typedef struct {
        logic [31:0]  pc;
        logic         hit;
        logic [127:0] line;
        int           lat;
        logic [31:0]  exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{32'h0000_1004, 1'b0, LINE_A, 17, 32'hBBAA9988};
        vecs[1] = '{32'h0000_100C, 1'b1, '0,      0, 32'h33221100};
        vecs[2] = '{32'h0000_1000, 1'b1, '0,      0, 32'hFFEEDDCC};
        vecs[3] = '{32'h0000_1018, 1'b0, LINE_B,  3, 32'h0000000C};
        vecs[4] = '{32'h0000_1400, 1'b0, LINE_C,  2, 32'hC0C0C0C0};
        vecs[5] = '{32'h0000_1014, 1'b1, '0,      0, 32'h0000000B};
        vecs[6] = '{32'h0000_1000, 1'b0, LINE_A,  1, 32'hFFEEDDCC};
        vecs[7] = '{32'h0000_1003, 1'b1, '0,      0, 32'hFFEEDDCC};
        vecs[8] = '{32'h0000_1408, 1'b0, LINE_C,  4, 32'hC2C2C2C2};

        rst = 1'b1; rdy = 1'b1; if_valid = 1'b0; if_pc = '0; if_rb = 1'b0;
        mc_fc_done = 1'b0; mc_fc_line = '0;
        #1;
        check("rst_done", 32'(if_done), 32'd0);
        check("rst_inst", if_inst, 32'd0);
        check("rst_fcv", 32'(mc_fc_valid), 32'd0);
        check("rst_addr", mc_fc_addr, 32'd0);
        check_stats();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].hit) fetch_hit(vecs[i].pc, vecs[i].exp);
            else fetch_miss(vecs[i].pc, vecs[i].line, vecs[i].lat, vecs[i].exp);
        end
        check_stats();

        // Rollback three cycles into the refill: line fills, no response.
        begin
            int d0;
            d0 = done_cnt;
            start_miss(32'h0000_2024);
            @(negedge clk);
            @(negedge clk);
            if_rb = 1'b1; if_valid = 1'b0;
            @(negedge clk);
            if_rb = 1'b0;
            check("rb_keep_req", 32'(mc_fc_valid), 32'd1);
            @(negedge clk);
            mc_fc_done = 1'b1; mc_fc_line = LINE_D;
            @(negedge clk);
            mc_fc_done = 1'b0;
            check("rb_nodone", 32'(if_done), 32'd0);
            check("rb_drop", 32'(mc_fc_valid), 32'd0);
            @(negedge clk);
            @(negedge clk);
            check("rb_no_pulse", 32'(done_cnt - d0), 32'd0);
            fetch_hit(32'h0000_2024, 32'hD1D1D1D1);
        end

        // Rollback coinciding with mc_fc_done.
        start_miss(32'h0000_2030);
        mc_fc_done = 1'b1; mc_fc_line = LINE_E; if_rb = 1'b1; if_valid = 1'b0;
        @(negedge clk);
        mc_fc_done = 1'b0; if_rb = 1'b0;
        check("rbd_nodone", 32'(if_done), 32'd0);
        check("rbd_drop", 32'(mc_fc_valid), 32'd0);
        @(negedge clk);
        fetch_hit(32'h0000_2030, 32'hE0E0E0E0);

        // Rollback in IDLE on a would-be miss: no request, no response.
        if_valid = 1'b1; if_pc = 32'h0000_1004; if_rb = 1'b1;
        @(negedge clk);
        check("rbi_noreq", 32'(mc_fc_valid), 32'd0);
        check("rbi_nodone", 32'(if_done), 32'd0);
        if_valid = 1'b0; if_rb = 1'b0;

        // rdy low in IDLE blocks a hit.
        if_valid = 1'b1; if_pc = 32'h0000_2030; rdy = 1'b0;
        @(negedge clk);
        check("stall_nohit", 32'(if_done), 32'd0);
        if_valid = 1'b0; rdy = 1'b1;
        @(negedge clk);

        // Refill completes while rdy is low; response deferred to the first rdy edge.
        start_miss(32'h0000_2044);
        @(negedge clk);
        rdy = 1'b0; mc_fc_done = 1'b1; mc_fc_line = LINE_F;
        @(negedge clk);
        mc_fc_done = 1'b0;
        check("rdy0_nodone", 32'(if_done), 32'd0);
        check("rdy0_drop", 32'(mc_fc_valid), 32'd0);
        @(negedge clk);
        check("rdy0_still", 32'(if_done), 32'd0);
        rdy = 1'b1;
        @(negedge clk);
        check("rdy1_done", 32'(if_done), 32'd1);
        check("rdy1_inst", if_inst, 32'hF1F1F1F1);
        if_valid = 1'b0;
        @(negedge clk);
        check("rdy1_single", 32'(if_done), 32'd0);
        fetch_hit(32'h0000_2040, 32'hF0F0F0F0);
        check_stats();

        // Asynchronous reset during a refill.
        start_miss(32'h0000_3000);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_fcv", 32'(mc_fc_valid), 32'd0);
        exp_hit = 0; exp_miss = 0;
        check_stats();
        if_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mc_fc_done = 1'b1; mc_fc_line = LINE_D;
        @(negedge clk);
        mc_fc_done = 1'b0;
        check("late_nodone", 32'(if_done), 32'd0);
        check("late_noreq", 32'(mc_fc_valid), 32'd0);
        @(negedge clk);
        fetch_miss(32'h0000_2030, LINE_E, 2, 32'hE0E0E0E0);
        fetch_miss(32'h0000_100C, LINE_A, 1, 32'h33221100);
        check_stats();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
